// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RV32I controller slice.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00,
    RES_RDATA  = 2'b01,
    RES_ALU    = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } alu_src_b_t;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

  function automatic logic is_wait_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Shared-memory handshake between the controller (master) and the memory port.
interface mc_controller_if;
  logic mem_ready;
  logic mem_read;
  logic mem_write;
  logic adr_src;

  modport master (input mem_ready, output mem_read, output mem_write, output adr_src);
  modport slave  (output mem_ready, input mem_read, input mem_write, input adr_src);
endinterface

// File: rtl/mc_alu_decoder.sv
// Combinational ALU operation decode; flags funct3 values the core does not implement.
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       op5,
  output logic [2:0] alu_ctrl,
  output logic       illegal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (aluop)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_ctrl = (op5 && funct7) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: illegal  = 1'b1;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM with bounded memory wait and sticky trap.
// Optional bne support is enabled by defining MC_CONTROLLER_BNE_EN.
module mc_controller
  import mc_pkg::*;
#(
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          op,
  input  logic [2:0]          funct3,
  input  logic                funct7,
  input  logic                is_zero,
  mc_controller_if.master     mem,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic [1:0]          result_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          imm_src,
  output logic [2:0]          alu_ctrl,
  output logic                fault,
  output logic [3:0]          state_dbg
);

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX  = TIMEOUT_W'(MEM_TIMEOUT);

  state_t                state, state_n;
  logic [TIMEOUT_W-1:0]  wait_cnt;
  logic                  waiting, timed_out;

  logic       pc_w, ir_w, rg_w, mrd, mwr, adr, fault_c;
  logic [1:0] aluop;
  logic       alu_illegal;

  mc_alu_decoder u_alu_dec (
    .aluop    (aluop),
    .funct3   (funct3),
    .funct7   (funct7),
    .op5      (op[5]),
    .alu_ctrl (alu_ctrl),
    .illegal  (alu_illegal)
  );

  assign waiting   = is_wait_state(state);
  // The trap fires on the edge where the count would reach MEM_TIMEOUT; a ready in that cycle wins.
  assign timed_out = waiting && !mem.mem_ready && (wait_cnt >= TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_n;
      if (state_n != state)
        wait_cnt <= '0;
      else if (waiting && !mem.mem_ready && (wait_cnt != TIMEOUT_MAX))
        wait_cnt <= wait_cnt + TIMEOUT_W'(1);
    end
  end

  always_comb begin
    state_n    = state;
    pc_w       = 1'b0;
    ir_w       = 1'b0;
    rg_w       = 1'b0;
    mrd        = 1'b0;
    mwr        = 1'b0;
    adr        = 1'b0;
    fault_c    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    imm_src    = IMM_I;
    aluop      = ALUOP_ADD;

    case (state)
      S_FETCH: begin
        mrd        = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        if (mem.mem_ready) begin
          ir_w    = 1'b1;
          pc_w    = 1'b1;
          state_n = S_DECODE;
        end else if (timed_out) begin
          state_n = S_TRAP;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
        case (op)
          OP_LOAD, OP_STORE: state_n = S_MEMADR;
          OP_RTYPE:          state_n = S_EXECUTER;
          OP_ITYPE:          state_n = S_EXECUTEI;
          OP_BRANCH:         state_n = S_BRANCH;
          OP_JAL:            state_n = S_JAL;
          default:           state_n = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        if (op == OP_STORE) begin
          imm_src = IMM_S;
          state_n = S_MEMWRITE;
        end else begin
          imm_src = IMM_I;
          state_n = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        adr = 1'b1;
        mrd = 1'b1;
        if (mem.mem_ready)  state_n = S_MEMWB;
        else if (timed_out) state_n = S_TRAP;
      end
      S_MEMWB: begin
        result_src = RES_RDATA;
        rg_w       = 1'b1;
        state_n    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr = 1'b1;
        mwr = 1'b1;
        if (mem.mem_ready)  state_n = S_FETCH;
        else if (timed_out) state_n = S_TRAP;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        aluop     = ALUOP_FUNCT;
        state_n   = alu_illegal ? S_TRAP : S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_I;
        aluop     = ALUOP_FUNCT;
        state_n   = alu_illegal ? S_TRAP : S_ALUWB;
      end
      S_ALUWB: begin
        rg_w    = 1'b1;
        state_n = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        aluop     = ALUOP_SUB;
        state_n   = S_FETCH;
        case (funct3)
          3'b000: pc_w = is_zero;
`ifdef MC_CONTROLLER_BNE_EN
          3'b001: pc_w = !is_zero;
`endif
          default: state_n = S_TRAP;
        endcase
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_w      = 1'b1;
        state_n   = S_ALUWB;
      end
      S_TRAP: fault_c = 1'b1;
      default: state_n = S_TRAP;
    endcase
  end

  assign pc_write      = pc_w & ~rst;
  assign ir_write      = ir_w & ~rst;
  assign reg_write     = rg_w & ~rst;
  assign mem.mem_read  = mrd & ~rst;
  assign mem.mem_write = mwr & ~rst;
  assign mem.adr_src   = adr;
  assign fault         = fault_c;
  assign state_dbg     = state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle expected outputs queued and checked against the DUT.
module tb_mc_controller;
  import mc_pkg::*;

  localparam int X = -1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7 = 1'b0;
  logic       is_zero = 1'b0;
  logic       pc_write, ir_write, reg_write, fault;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_ctrl;
  logic [3:0] state_dbg;

  mc_controller_if mem_if ();

  mc_controller #(.TIMEOUT_W(8), .MEM_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7     (funct7),
    .is_zero    (is_zero),
    .mem        (mem_if.master),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .imm_src    (imm_src),
    .alu_ctrl   (alu_ctrl),
    .fault      (fault),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [21:0] val;
    logic [21:0] mask;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Fields: state, pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, fault,
  // result_src, alu_src_a, alu_src_b, imm_src, alu_ctrl; X = not checked.
  function automatic exp_t mk(string tag, int st, int pcw, int irw, int adr, int mrd, int mwr,
                              int rgw, int flt, int res, int a, int b, int imm, int alu);
    exp_t e;
    int v[13];
    int lo[13] = '{18, 17, 16, 15, 14, 13, 12, 11, 9, 7, 5, 3, 0};
    int wd[13] = '{4, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 3};
    v = '{st, pcw, irw, adr, mrd, mwr, rgw, flt, res, a, b, imm, alu};
    e.tag  = tag;
    e.val  = '0;
    e.mask = '0;
    for (int unsigned k = 0; k < 13; k++)
      if (v[k] >= 0)
        for (int unsigned i = 0; i < 32'(wd[k]); i++) begin
          e.val[lo[k] + int'(i)]  = v[k][i];
          e.mask[lo[k] + int'(i)] = 1'b1;
        end
    return e;
  endfunction

  function automatic exp_t e_fetch(string t, int rdy);
    return mk(t, S_FETCH, rdy, rdy, 0, 1, 0, 0, 0, 2, 0, 2, X, 0);
  endfunction
  function automatic exp_t e_decode(string t);
    return mk(t, S_DECODE, 0, 0, X, 0, 0, 0, 0, X, 1, 1, 2, 0);
  endfunction
  function automatic exp_t e_memadr(string t, int store);
    return mk(t, S_MEMADR, 0, 0, X, 0, 0, 0, 0, X, 2, 1, store, 0);
  endfunction
  function automatic exp_t e_memread(string t);
    return mk(t, S_MEMREAD, 0, 0, 1, 1, 0, 0, 0, 0, X, X, X, X);
  endfunction
  function automatic exp_t e_memwb(string t);
    return mk(t, S_MEMWB, 0, 0, X, 0, 0, 1, 0, 1, X, X, X, X);
  endfunction
  function automatic exp_t e_memwrite(string t);
    return mk(t, S_MEMWRITE, 0, 0, 1, 0, 1, 0, 0, 0, X, X, X, X);
  endfunction
  function automatic exp_t e_execr(string t, int alu);
    return mk(t, S_EXECUTER, 0, 0, X, 0, 0, 0, 0, X, 2, 0, X, alu);
  endfunction
  function automatic exp_t e_execi(string t, int alu);
    return mk(t, S_EXECUTEI, 0, 0, X, 0, 0, 0, 0, X, 2, 1, 0, alu);
  endfunction
  function automatic exp_t e_aluwb(string t);
    return mk(t, S_ALUWB, 0, 0, X, 0, 0, 1, 0, 0, X, X, X, X);
  endfunction
  function automatic exp_t e_branch(string t, int pcw);
    return mk(t, S_BRANCH, pcw, 0, X, 0, 0, 0, 0, 0, 2, 0, X, 1);
  endfunction
  function automatic exp_t e_jal(string t);
    return mk(t, S_JAL, 1, 0, X, 0, 0, 0, 0, 0, 1, 2, X, 0);
  endfunction
  function automatic exp_t e_trap(string t);
    return mk(t, S_TRAP, 0, 0, X, 0, 0, 0, 1, X, X, X, X, X);
  endfunction
  // Reset cycle: state is whatever was current, every strobe must be low.
  function automatic exp_t e_rst(string t, int st);
    return mk(t, st, 0, 0, X, 0, 0, 0, X, X, X, X, X, X);
  endfunction

  task automatic check();
    exp_t        e;
    logic [21:0] obs;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty: observed 0 entries required 1");
      return;
    end
    e   = sb.pop_front();
    obs = {state_dbg, pc_write, ir_write, mem_if.adr_src, mem_if.mem_read, mem_if.mem_write,
           reg_write, fault, result_src, alu_src_a, alu_src_b, imm_src, alu_ctrl};
    assert ((obs & e.mask) === (e.val & e.mask)) else begin
      mismatched++;
      $error("FAIL %s: observed %h required %h (mask %h)", e.tag, obs & e.mask, e.val & e.mask, e.mask);
    end
  endtask

  task automatic cyc(input logic r, input logic rdy, input logic iz, input exp_t e);
    @(negedge clk);
    rst              = r;
    mem_if.mem_ready = rdy;
    is_zero          = iz;
    sb.push_back(e);
    #1;
    check();
  endtask

  task automatic go(input logic rdy, input exp_t e);
    cyc(1'b0, rdy, 1'b0, e);
  endtask

  task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7 = f7;
  endtask

  initial begin
    mem_if.mem_ready = 1'b0;

    // Reset: strobes low even with mem_ready high while in FETCH.
    cyc(1'b1, 1'b0, 1'b0, e_rst("rst0", X));
    cyc(1'b1, 1'b1, 1'b0, mk("rst1", S_FETCH, 0, 0, X, 0, 0, 0, 0, X, X, X, X, X));

    // lw: 3 wait cycles in FETCH, 2 in MEMREAD.
    instr(OP_LOAD, 3'b010, 1'b0);
    go(1'b0, e_fetch("lw_f0", 0));
    go(1'b0, e_fetch("lw_f1", 0));
    go(1'b0, e_fetch("lw_f2", 0));
    go(1'b1, e_fetch("lw_f3", 1));
    go(1'b0, e_decode("lw_d"));
    go(1'b0, e_memadr("lw_ma", 0));
    go(1'b0, e_memread("lw_mr0"));
    go(1'b0, e_memread("lw_mr1"));
    go(1'b1, e_memread("lw_mr2"));
    go(1'b0, e_memwb("lw_wb"));

    // R-type sub.
    instr(OP_RTYPE, 3'b000, 1'b1);
    go(1'b1, e_fetch("sub_f", 1));
    go(1'b0, e_decode("sub_d"));
    go(1'b0, e_execr("sub_ex", ALU_SUB));
    go(1'b0, e_aluwb("sub_wb"));

    // R-type slt, then addi-form or (funct7 ignored for I-type).
    instr(OP_RTYPE, 3'b010, 1'b0);
    go(1'b1, e_fetch("slt_f", 1));
    go(1'b0, e_decode("slt_d"));
    go(1'b0, e_execr("slt_ex", ALU_SLT));
    go(1'b0, e_aluwb("slt_wb"));
    instr(OP_ITYPE, 3'b000, 1'b1);
    go(1'b1, e_fetch("addi_f", 1));
    go(1'b0, e_decode("addi_d"));
    go(1'b0, e_execi("addi_ex", ALU_ADD));
    go(1'b0, e_aluwb("addi_wb"));
    instr(OP_ITYPE, 3'b111, 1'b0);
    go(1'b1, e_fetch("andi_f", 1));
    go(1'b0, e_decode("andi_d"));
    go(1'b0, e_execi("andi_ex", ALU_AND));
    go(1'b0, e_aluwb("andi_wb"));

    // beq taken / not taken.
    instr(OP_BRANCH, 3'b000, 1'b0);
    go(1'b1, e_fetch("beq1_f", 1));
    go(1'b0, e_decode("beq1_d"));
    cyc(1'b0, 1'b0, 1'b1, e_branch("beq1_br", 1));
    go(1'b1, e_fetch("beq0_f", 1));
    go(1'b0, e_decode("beq0_d"));
    cyc(1'b0, 1'b0, 1'b0, e_branch("beq0_br", 0));

    // jal.
    instr(OP_JAL, 3'b000, 1'b0);
    go(1'b1, e_fetch("jal_f", 1));
    go(1'b0, e_decode("jal_d"));
    go(1'b0, e_jal("jal_j"));
    go(1'b0, e_aluwb("jal_wb"));

    // sw: ready on the 4th waiting cycle wins over the timeout.
    instr(OP_STORE, 3'b010, 1'b0);
    go(1'b1, e_fetch("sw_f", 1));
    go(1'b0, e_decode("sw_d"));
    go(1'b0, e_memadr("sw_ma", 1));
    go(1'b0, e_memwrite("sw_mw0"));
    go(1'b0, e_memwrite("sw_mw1"));
    go(1'b0, e_memwrite("sw_mw2"));
    go(1'b1, e_memwrite("sw_mw3"));
    // Counter must restart on FETCH entry.
    go(1'b0, e_fetch("sw_nf0", 0));
    go(1'b0, e_fetch("sw_nf1", 0));
    go(1'b0, e_fetch("sw_nf2", 0));
    go(1'b1, e_fetch("sw_nf3", 1));

    // sw: mem_ready never comes -> TRAP after 4 waiting cycles.
    go(1'b0, e_decode("swto_d"));
    go(1'b0, e_memadr("swto_ma", 1));
    go(1'b0, e_memwrite("swto_mw0"));
    go(1'b0, e_memwrite("swto_mw1"));
    go(1'b0, e_memwrite("swto_mw2"));
    go(1'b0, e_memwrite("swto_mw3"));
    go(1'b1, e_trap("swto_trap0"));
    go(1'b0, e_trap("swto_trap1"));
    cyc(1'b1, 1'b1, 1'b0, e_rst("swto_rst", S_TRAP));
    go(1'b0, e_fetch("swto_after", 0));

    // Illegal opcode.
    instr(7'b0000000, 3'b000, 1'b0);
    go(1'b1, e_fetch("ill_f", 1));
    go(1'b0, e_decode("ill_d"));
    go(1'b1, e_trap("ill_trap0"));
    go(1'b0, e_trap("ill_trap1"));
    go(1'b1, e_trap("ill_trap2"));
    cyc(1'b1, 1'b0, 1'b0, e_rst("ill_rst", S_TRAP));
    go(1'b0, e_fetch("ill_after", 0));

    // Unsupported funct3 in EXECUTER traps without writeback.
    instr(OP_RTYPE, 3'b001, 1'b0);
    go(1'b1, e_fetch("f3_f", 1));
    go(1'b0, e_decode("f3_d"));
    go(1'b0, e_execr("f3_ex", X));
    go(1'b0, e_trap("f3_trap"));
    cyc(1'b1, 1'b0, 1'b0, e_rst("f3_rst", S_TRAP));

    // bne.
    instr(OP_BRANCH, 3'b001, 1'b0);
    go(1'b1, e_fetch("bne_f", 1));
    go(1'b0, e_decode("bne_d"));
`ifdef MC_CONTROLLER_BNE_EN
    cyc(1'b0, 1'b0, 1'b0, e_branch("bne_br", 1));
    go(1'b0, e_fetch("bne_next", 0));
`else
    cyc(1'b0, 1'b0, 1'b0, e_branch("bne_br", 0));
    go(1'b0, e_trap("bne_trap"));
    cyc(1'b1, 1'b0, 1'b0, e_rst("bne_rst", S_TRAP));
`endif

    // Reset in the middle of a MEMREAD wait.
    instr(OP_LOAD, 3'b010, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, e_fetch("mrst_f", 1));
    go(1'b0, e_decode("mrst_d"));
    go(1'b0, e_memadr("mrst_ma", 0));
    go(1'b0, e_memread("mrst_mr"));
    cyc(1'b1, 1'b1, 1'b0, e_rst("mrst_rst", S_MEMREAD));
    go(1'b0, e_fetch("mrst_after", 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle RV32I control unit; next generation of the single-cycle controller.
- Sequences each instruction through a Moore FSM: fetch, decode, execute, memory, writeback.
- Drives a shared-memory datapath through a ready handshake, with a bounded wait timeout and a sticky trap on illegal opcodes or memory timeout.
- Instantiated beside the multicycle datapath in the core top level.

Parameters:
- TIMEOUT_W, 8, width of the memory-wait counter.
- MEM_TIMEOUT, 200, maximum cycles spent waiting for mem_ready before trapping; must be below 2**TIMEOUT_W.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  7  instr[6:0] from the instruction register.
- funct3  in  3  instr[14:12].
- funct7  in  1  instr[30].
- is_zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current read or write this cycle.
- pc_write  out  1  PC register load enable.
- ir_write  out  1  instruction register and old-PC load enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write enable.
- result_src  out  2  result select: 00 = ALUOut, 01 = read data, 10 = ALU result.
- alu_src_a  out  2  ALU operand A: 00 = PC, 01 = old PC, 10 = rs1.
- alu_src_b  out  2  ALU operand B: 00 = rs2, 01 = immediate, 10 = constant 4.
- imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- alu_ctrl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- fault  out  1  sticky trap indicator.
- state_dbg  out  4  current state encoding.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- On reset: state = FETCH, wait counter = 0, fault = 0.
- While rst = 1, every strobe output (pc_write, ir_write, mem_read, mem_write, reg_write) is forced to 0.
- Outputs are combinational from state; in wait states they also depend on mem_ready and is_zero.
- No output depends on op except alu_ctrl and imm_src.
- FETCH:
  - adr_src = 0, mem_read = 1, alu_src_a = 00, alu_src_b = 10, alu_ctrl = add, result_src = 10.
  - ir_write and pc_write assert only in the cycle mem_ready = 1; the FSM then moves to DECODE. Otherwise it holds.
- DECODE:
  - alu_src_a = 01, alu_src_b = 01, imm_src = 10, add (precomputes the branch target).
  - Next state by op:
    - 0000011 (load) or 0100011 (store) -> MEMADR.
    - 0110011 -> EXECUTER.
    - 0010011 -> EXECUTEI.
    - 1100011 -> BRANCH.
    - 1101111 -> JAL.
    - Any other op -> TRAP.
- MEMADR: alu_src_a = 10, alu_src_b = 01, add, imm_src = 00 for load / 01 for store. Next MEMREAD (load) or MEMWRITE (store).
- MEMREAD: adr_src = 1, mem_read = 1, result_src = 00. Holds until mem_ready, then MEMWB.
- MEMWB: result_src = 01, reg_write = 1. Next FETCH.
- MEMWRITE: adr_src = 1, mem_write = 1, result_src = 00. Holds until mem_ready, then FETCH.
- EXECUTER: alu_src_a = 10, alu_src_b = 00, ALU decode. Next ALUWB.
- EXECUTEI: alu_src_a = 10, alu_src_b = 01, imm_src = 00, ALU decode. Next ALUWB.
- ALU decode by funct3:
  - 000: sub when op = 0110011 and funct7 = 1, else add.
  - 010: slt. 110: or. 111: and.
  - Any other funct3 -> TRAP on the next edge; the instruction is not executed.
- ALUWB: result_src = 00, reg_write = 1. Next FETCH.
- BRANCH:
  - alu_src_a = 10, alu_src_b = 00, sub, result_src = 00.
  - funct3 = 000 (beq): pc_write = is_zero.
  - Next FETCH.
- JAL: alu_src_a = 01, alu_src_b = 10, add, result_src = 00, pc_write = 1. Next ALUWB (writes PC+4 to rd).
- Wait counter:
  - Cleared on entry to FETCH, MEMREAD or MEMWRITE.
  - Increments each cycle the FSM stays in one of those states with mem_ready = 0, saturating at MEM_TIMEOUT.
  - Reaching MEM_TIMEOUT with mem_ready still 0 -> TRAP on the next edge.
  - mem_ready = 1 in the same cycle the count hits MEM_TIMEOUT: the ready wins and the normal transition is taken.
- TRAP: fault = 1, all strobes = 0. Leaves only on rst.
- Reset in mid-wait or mid-instruction: returns to FETCH next edge; no strobe asserts in the reset cycle.

Optional Feature:
- Macro MC_CONTROLLER_BNE_EN.
- Defined: BRANCH with funct3 = 001 (bne) is legal; pc_write = !is_zero.
- Undefined: any branch funct3 other than 000 -> TRAP from BRANCH with pc_write = 0.

Decomposition:
- Shared package mc_pkg holds:
  - State enum (4 bits).
  - Opcode constants.
  - alu_ctrl, result_src, alu_src_a/b and imm_src encodings.
- One sub-module, mc_alu_decoder: combinational; inputs aluop[1:0] (00 add, 01 sub, 10 funct), funct3, funct7, op[5]; outputs alu_ctrl and an illegal flag.
- FSM, wait counter and output decode stay in mc_controller.

Test Plan:
- lw with mem_ready delayed 3 cycles in FETCH and 2 in MEMREAD -> states F,F,F,F,D,MA,MR,MR,MR,WB; ir_write exactly one pulse; reg_write in WB with result_src = 01.
- R-type sub (op 0110011, funct3 000, funct7 1), mem_ready = 1 -> EXECUTER drives alu_ctrl = 001; ALUWB reg_write = 1; back to FETCH 4 cycles after entering FETCH.
- beq with is_zero = 1, then with is_zero = 0 -> pc_write = 1 / 0 in BRANCH; 3-cycle instruction each.
- jal -> JAL pc_write = 1, alu_src_a = 01, alu_src_b = 10; then ALUWB reg_write = 1.
- Illegal op 0000000 -> TRAP after DECODE with fault = 1; mem_ready toggling has no effect; rst returns to FETCH with fault = 0.
- MEM_TIMEOUT = 4, mem_ready held 0 in MEMWRITE -> TRAP after 4 waiting cycles; mem_ready = 1 on the 4th cycle instead -> FETCH, no trap.
